instr_sequencer: RTL

- Program-issue engine that drives the datapath's 21-bit instruction port and its ld strobe, one instruction per issue cycle.
- A host writes a short program into an internal buffer. On start, the block replays the program a programmable number of times, then signals done.
- It sits directly upstream of the CPU core. Its instruction/ld outputs connect 1:1 to the core's instruction/ld inputs.

---
 rtl/instr_sequencer_if.sv | 49 ++++
 rtl/instr_sequencer.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if
//   Bundles the host-facing program/control bus and the core-facing issue
//   port of instr_sequencer into one interface.
//   Macro: SEQ_STEP_EN adds the single-step input 'step'.
//
//   Host side (master drives, slave receives):
//     prog_we, prog_addr[AW-1:0], prog_data[IW-1:0]  program buffer write
//     prog_len[AW:0], loop_cnt[7:0]                  run length and extra passes
//     start, stop                                    run control
//     step (SEQ_STEP_EN only)                        single-step issue strobe
//   Core side (slave drives, master receives):
//     instruction[IW-1:0], ld                        issued word and its strobe
//     pc[AW-1:0], busy, done                         status
interface instr_sequencer_if #(
  parameter int AW = 4,
  parameter int IW = 21
);
  logic          prog_we;
  logic [AW-1:0] prog_addr;
  logic [IW-1:0] prog_data;
  logic [AW:0]   prog_len;
  logic [7:0]    loop_cnt;
  logic          start;
  logic          stop;
`ifdef SEQ_STEP_EN
  logic          step;
`endif
  logic [IW-1:0] instruction;
  logic          ld;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  modport master (
`ifdef SEQ_STEP_EN
    output step,
`endif
    output prog_we, prog_addr, prog_data, prog_len, loop_cnt, start, stop,
    input  instruction, ld, pc, busy, done
  );

  modport slave (
`ifdef SEQ_STEP_EN
    input  step,
`endif
    input  prog_we, prog_addr, prog_data, prog_len, loop_cnt, start, stop,
    output instruction, ld, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// instr_sequencer
//   Program-issue engine in front of the CPU core. A host loads up to DEPTH
//   instruction words into an internal buffer; on start the buffer is
//   replayed prog_len entries at a time, loop_cnt+1 times, one instruction
//   per cycle on instruction/ld, followed by a one-cycle done pulse.
//   Macro: SEQ_STEP_EN -- when defined, each issue in RUN waits for a 'step'
//   pulse (one instruction per pulse); when undefined, issue every cycle.
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous active-low reset
//     bus   instr_sequencer_if.slave (program write, control, issue port,
//           status; see the interface file for the signal list)
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int IW    = 21
) (
  input  logic                   clk,
  input  logic                   rst,
  instr_sequencer_if.slave       bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Without single-step, the first instruction is issued straight out of
  // the start cycle so ld rises the cycle after start is sampled.
`ifdef SEQ_STEP_EN
  localparam bit ISSUE_ON_START = 1'b0;
`else
  localparam bit ISSUE_ON_START = 1'b1;
`endif

  state_t        state, state_nx;
  logic [IW-1:0] mem [DEPTH];

  logic [AW-1:0] pc, pc_nx;
  logic [AW-1:0] idx, idx_nx;        // next buffer entry to issue
  logic [AW:0]   len, len_nx;
  logic [7:0]    passes, passes_nx;  // passes still to run after this one
  logic          fin, fin_nx;        // every instruction of the run is issued
  logic          ld, ld_nx;
  logic          busy, busy_nx;
  logic          done, done_nx;
  logic [IW-1:0] instruction;
  logic          issue;
  logic          instr_hold;
  logic          step_ok;
  logic          len_ok;

  logic [AW-1:0] sel_idx;
  logic [AW:0]   sel_len;
  logic [7:0]    sel_passes;
  logic [AW-1:0] adv_idx;
  logic [7:0]    adv_passes;
  logic          adv_fin;

`ifdef SEQ_STEP_EN
  assign step_ok = bus.step;
`else
  assign step_ok = 1'b1;
`endif

  assign len_ok = (bus.prog_len != '0) && (bus.prog_len <= (AW+1)'(DEPTH));

  // Program buffer: written only while idle, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.prog_we)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  // Pass bookkeeping for the entry about to be issued. From IDLE the run
  // parameters come straight from the ports because they are latched in the
  // same cycle as the first issue.
  always_comb begin
    if (state == IDLE) begin
      sel_idx    = '0;
      sel_len    = bus.prog_len;
      sel_passes = bus.loop_cnt;
    end else begin
      sel_idx    = idx;
      sel_len    = len;
      sel_passes = passes;
    end
    adv_idx    = sel_idx + 1'b1;
    adv_passes = sel_passes;
    adv_fin    = 1'b0;
    if ({1'b0, sel_idx} == sel_len - 1'b1) begin
      if (sel_passes == 8'd0) begin
        adv_idx = sel_idx;
        adv_fin = 1'b1;
      end else begin
        adv_idx    = '0;
        adv_passes = sel_passes - 8'd1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    idx_nx     = idx;
    len_nx     = len;
    passes_nx  = passes;
    fin_nx     = fin;
    ld_nx      = 1'b0;
    done_nx    = 1'b0;
    issue      = 1'b0;
    instr_hold = 1'b0;
    case (state)
      IDLE: begin
        // stop has priority over start; out-of-range lengths are ignored.
        if (bus.start && !bus.stop && len_ok) begin
          state_nx  = RUN;
          len_nx    = bus.prog_len;
          passes_nx = bus.loop_cnt;
          idx_nx    = '0;
          pc_nx     = '0;
          fin_nx    = 1'b0;
          if (ISSUE_ON_START) begin
            ld_nx     = 1'b1;
            issue     = 1'b1;
            idx_nx    = adv_idx;
            passes_nx = adv_passes;
            fin_nx    = adv_fin;
          end
        end
      end
      RUN: begin
        // The instruction presented this cycle is complete either way; stop
        // or the end of the final pass only suppresses the next issue.
        if (bus.stop || fin) begin
          state_nx = DONE;
          done_nx  = 1'b1;
        end else if (step_ok) begin
          ld_nx     = 1'b1;
          issue     = 1'b1;
          pc_nx     = idx;
          idx_nx    = adv_idx;
          passes_nx = adv_passes;
          fin_nx    = adv_fin;
        end else begin
          instr_hold = 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
    busy_nx = (state_nx == RUN);
  end

  // State and output registers. The buffer read is addressed by pc_nx so the
  // word lands in the instruction register together with ld.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      pc          <= '0;
      idx         <= '0;
      len         <= '0;
      passes      <= '0;
      fin         <= 1'b0;
      ld          <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      instruction <= '0;
    end else begin
      state  <= state_nx;
      pc     <= pc_nx;
      idx    <= idx_nx;
      len    <= len_nx;
      passes <= passes_nx;
      fin    <= fin_nx;
      ld     <= ld_nx;
      busy   <= busy_nx;
      done   <= done_nx;
      if (issue)
        instruction <= mem[pc_nx];
      else if (!instr_hold)
        instruction <= '0;
    end
  end

  assign bus.instruction = instruction;
  assign bus.ld          = ld;
  assign bus.pc          = pc;
  assign bus.busy        = busy;
  assign bus.done        = done;

endmodule
